// File: rtl/danmaku_ctl_axil_slave_if.sv
// AXI4-Lite bus bundle between the PS master port and the Danmaku control register file.
interface danmaku_ctl_axil_slave_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
        input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );

    modport slave (
        input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
        input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
    );
endinterface

// File: rtl/danmaku_ctl_axil_slave.sv
// AXI4-Lite register file for the Danmaku overlay: CTRL/CFG/STATUS/IRQ_EN/IRQ_PEND
// with independent AW/W acceptance and a level interrupt built from pending & enable.
module danmaku_ctl_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_IRQ            = 8
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    danmaku_ctl_axil_slave_if.slave s_axi,
    output logic [31:0]          ctrl_out,
    output logic [31:0]          cfg_out,
    input  logic [31:0]          status_in,
    input  logic [NUM_IRQ-1:0]   irq_event_in,
    output logic                 irq
);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] IRQ_MASK    = 32'hFFFF_FFFF >> (32 - NUM_IRQ);

    logic                          rdy_en_reg;
    logic                          aw_held_reg;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_reg;
    logic                          w_held_reg;
    logic [31:0]                   w_data_reg;
    logic [3:0]                    w_strb_reg;
    logic                          bvalid_reg;
    logic [1:0]                    bresp_reg;
    logic                          rvalid_reg;
    logic [1:0]                    rresp_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
    logic [31:0]                   ctrl_reg, cfg_reg, irq_en_reg, irq_pend_reg;
    logic                          irq_reg;

    logic                          aw_fire, w_fire, ar_fire, commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [2:0]                    wr_idx;
    logic [31:0]                   wr_data, wr_mask, wr_bits, pend_clr, evt_ext;
    logic [3:0]                    wr_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
    logic [1:0]                    rd_resp;
    logic                          unused_bits;

    // rdy_en_reg keeps every ready low while reset is asserted
    assign s_axi.S_AXI_AWREADY = rdy_en_reg && !aw_held_reg && !bvalid_reg;
    assign s_axi.S_AXI_WREADY  = rdy_en_reg && !w_held_reg  && !bvalid_reg;
    assign s_axi.S_AXI_ARREADY = rdy_en_reg && !rvalid_reg;
    assign s_axi.S_AXI_BVALID  = bvalid_reg;
    assign s_axi.S_AXI_BRESP   = bresp_reg;
    assign s_axi.S_AXI_RVALID  = rvalid_reg;
    assign s_axi.S_AXI_RRESP   = rresp_reg;
    assign s_axi.S_AXI_RDATA   = rdata_reg;

    assign aw_fire = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_fire  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
    assign ar_fire = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign commit  = (aw_held_reg || aw_fire) && (w_held_reg || w_fire);

    assign wr_addr = aw_held_reg ? aw_addr_reg : s_axi.S_AXI_AWADDR;
    assign wr_data = w_held_reg  ? w_data_reg  : s_axi.S_AXI_WDATA;
    assign wr_strb = w_held_reg  ? w_strb_reg  : s_axi.S_AXI_WSTRB;
    assign wr_idx  = wr_addr[4:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_strb
            assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
        end
    endgenerate

    assign wr_bits  = wr_data & wr_mask;
    assign pend_clr = (commit && wr_idx == 3'd4) ? wr_bits : 32'd0;

    always_comb begin
        evt_ext = '0;
        evt_ext[NUM_IRQ-1:0] = irq_event_in;
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (s_axi.S_AXI_ARADDR[4:2])
            3'd0:    rd_data = {ctrl_reg[31:1], 1'b0};
            3'd1:    rd_data = cfg_reg;
            3'd2:    rd_data = status_in;
            3'd3:    rd_data = irq_en_reg;
            3'd4:    rd_data = irq_pend_reg;
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, wr_addr[1:0],
                           s_axi.S_AXI_ARADDR[1:0]};

    // Write channel holding registers and response
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdy_en_reg  <= 1'b0;
            aw_held_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            rdy_en_reg <= 1'b1;
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= (wr_idx > 3'd4) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_fire) begin
                    aw_held_reg <= 1'b1;
                    aw_addr_reg <= s_axi.S_AXI_AWADDR;
                end
                if (w_fire) begin
                    w_held_reg <= 1'b1;
                    w_data_reg <= s_axi.S_AXI_WDATA;
                    w_strb_reg <= s_axi.S_AXI_WSTRB;
                end
                if (bvalid_reg && s_axi.S_AXI_BREADY)
                    bvalid_reg <= 1'b0;
            end
        end
    end

    // Register file; ctrl_reg[0] is the START pulse and drops back every cycle
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_reg     <= '0;
            cfg_reg      <= '0;
            irq_en_reg   <= '0;
            irq_pend_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            ctrl_reg[0] <= 1'b0;
            if (commit) begin
                case (wr_idx)
                    3'd0: ctrl_reg   <= {(ctrl_reg[31:1] & ~wr_mask[31:1]) | wr_bits[31:1],
                                         wr_bits[0]};
                    3'd1: cfg_reg    <= (cfg_reg & ~wr_mask) | wr_bits;
                    3'd3: irq_en_reg <= ((irq_en_reg & ~wr_mask) | wr_bits) & IRQ_MASK;
                    default: ;
                endcase
            end
            // new events override a simultaneous clear of the same bit
            irq_pend_reg <= ((irq_pend_reg & ~pend_clr) | evt_ext) & IRQ_MASK;
            irq_reg      <= |(irq_pend_reg & irq_en_reg);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else if (ar_fire) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= rd_resp;
            rdata_reg  <= rd_data;
        end else if (rvalid_reg && s_axi.S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign ctrl_out = ctrl_reg;
    assign cfg_out  = cfg_reg;
    assign irq      = irq_reg;
endmodule

// File: tb/tb_danmaku_ctl_axil_slave.sv
// Randomised bench for danmaku_ctl_axil_slave against a register-map model of the control block.
module tb_danmaku_ctl_axil_slave;
    logic        tb_ACLK = 1'b0;
    logic        rst_n;
    logic [31:0] ctrl_out, cfg_out, status_in;
    logic [7:0]  irq_event_in;
    logic        irq;
    int          n_checks = 0;
    int          n_errors = 0;

    // model state
    logic [31:0] m_ctrl, m_cfg, m_en, m_pend;

    always #5 tb_ACLK = ~tb_ACLK;

    danmaku_ctl_axil_slave_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    danmaku_ctl_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_IRQ(8)
    ) dut (
        .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(rst_n), .s_axi(bus.slave),
        .ctrl_out(ctrl_out), .cfg_out(cfg_out), .status_in(status_in),
        .irq_event_in(irq_event_in), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a / 4)
            0: return m_ctrl & 32'hFFFF_FFFE;
            1: return m_cfg;
            2: return status_in;
            3: return m_en;
            4: return m_pend;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_resp(input logic [4:0] a);
        return (a / 4 >= 5) ? 2'b10 : 2'b00;
    endfunction

    task automatic step();
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
    endtask

    // Called at a negedge; AW and W start after their own delays.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input logic [7:0] ev);
        bit          aw_done = 0, w_done = 0, aw_hs, w_hs, start;
        int          cyc = 0;
        logic [31:0] msk, bits;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.S_AXI_AWADDR  = addr;
            bus.S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            bus.S_AXI_WDATA   = data;
            bus.S_AXI_WSTRB   = strb;
            bus.S_AXI_WVALID  = !w_done && cyc >= w_dly;
            aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            irq_event_in = ((aw_done || aw_hs) && (w_done || w_hs)) ? ev : 8'h00;
            step();
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            if (aw_done && !w_done) chk("awready_held", {31'd0, bus.S_AXI_AWREADY}, 0);
            if (w_done && !aw_done) chk("wready_held", {31'd0, bus.S_AXI_WREADY}, 0);
            cyc++;
        end
        bus.S_AXI_AWVALID = 0;
        bus.S_AXI_WVALID  = 0;
        irq_event_in      = 0;
        if (!(aw_done && w_done)) begin
            chk("wr_timeout", 0, 1);
            return;
        end
        msk = 0;
        for (int b = 0; b < 4; b++) if (strb[b]) msk[b*8 +: 8] = 8'hFF;
        bits  = data & msk;
        start = (addr / 4 == 0) && strb[0] && data[0];
        case (addr / 4)
            0: m_ctrl = ((m_ctrl & ~msk) | bits) & 32'hFFFF_FFFE;
            1: m_cfg  = (m_cfg & ~msk) | bits;
            3: m_en   = ((m_en & ~msk) | bits) & 32'hFF;
            4: m_pend = m_pend & ~bits;
            default: ;
        endcase
        m_pend = m_pend | {24'd0, ev};
        $display("WR addr=%02h data=%08h strb=%h aw_dly=%0d w_dly=%0d b_dly=%0d ev=%02h",
                 addr, data, strb, aw_dly, w_dly, b_dly, ev);
        chk("bvalid", {31'd0, bus.S_AXI_BVALID}, 1);
        chk("bresp", {30'd0, bus.S_AXI_BRESP}, {30'd0, m_resp(addr)});
        chk("ctrl_start", ctrl_out, m_ctrl | {31'd0, start});
        chk("cfg_out", cfg_out, m_cfg);
        chk("awready_b", {31'd0, bus.S_AXI_AWREADY}, 0);
        for (int i = 0; i < b_dly; i++) begin
            step();
            chk("bvalid_hold", {31'd0, bus.S_AXI_BVALID}, 1);
            chk("bresp_hold", {30'd0, bus.S_AXI_BRESP}, {30'd0, m_resp(addr)});
            chk("wready_b", {31'd0, bus.S_AXI_WREADY}, 0);
            chk("awready_b", {31'd0, bus.S_AXI_AWREADY}, 0);
            chk("ctrl_after", ctrl_out, m_ctrl);
        end
        bus.S_AXI_BREADY = 1;
        step();
        bus.S_AXI_BREADY = 0;
        chk("bvalid_done", {31'd0, bus.S_AXI_BVALID}, 0);
        chk("ctrl_after", ctrl_out, m_ctrl);
        chk("irq", {31'd0, irq}, {31'd0, (m_pend & m_en) != 0});
    endtask

    task automatic axi_read(input logic [4:0] addr, input int r_dly, input bit vary_status);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int          n = 0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1;
        while (!bus.S_AXI_ARREADY && n < 20) begin
            step();
            n++;
        end
        if (!bus.S_AXI_ARREADY) begin
            bus.S_AXI_ARVALID = 0;
            chk("rd_timeout", 0, 1);
            return;
        end
        exp_d = m_read(addr);
        exp_r = m_resp(addr);
        step();
        bus.S_AXI_ARVALID = 0;
        $display("RD addr=%02h exp=%08h resp=%0d r_dly=%0d", addr, exp_d, exp_r, r_dly);
        chk("rvalid", {31'd0, bus.S_AXI_RVALID}, 1);
        chk("rdata", bus.S_AXI_RDATA, exp_d);
        chk("rresp", {30'd0, bus.S_AXI_RRESP}, {30'd0, exp_r});
        for (int i = 0; i < r_dly; i++) begin
            if (vary_status) status_in = $urandom;
            step();
            chk("rdata_hold", bus.S_AXI_RDATA, exp_d);
            chk("arready_r", {31'd0, bus.S_AXI_ARREADY}, 0);
        end
        bus.S_AXI_RREADY = 1;
        step();
        bus.S_AXI_RREADY = 0;
        chk("rvalid_done", {31'd0, bus.S_AXI_RVALID}, 0);
    endtask

    task automatic pulse_events(input logic [7:0] ev);
        irq_event_in = ev;
        step();
        irq_event_in = 0;
        m_pend = m_pend | {24'd0, ev};
        step();
        $display("EV ev=%02h pend=%02h", ev, m_pend);
        chk("irq_ev", {31'd0, irq}, {31'd0, (m_pend & m_en) != 0});
    endtask

    initial begin
        rst_n = 0;
        bus.S_AXI_AWADDR = 0; bus.S_AXI_AWPROT = 0; bus.S_AXI_AWVALID = 0;
        bus.S_AXI_WDATA = 0;  bus.S_AXI_WSTRB = 0;  bus.S_AXI_WVALID = 0;
        bus.S_AXI_BREADY = 0;
        bus.S_AXI_ARADDR = 0; bus.S_AXI_ARPROT = 0; bus.S_AXI_ARVALID = 0;
        bus.S_AXI_RREADY = 0;
        status_in = 0; irq_event_in = 0;
        m_ctrl = 0; m_cfg = 0; m_en = 0; m_pend = 0;
        repeat (3) @(negedge tb_ACLK);
        chk("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 0);
        chk("rst_wready", {31'd0, bus.S_AXI_WREADY}, 0);
        chk("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 0);
        chk("rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 0);
        chk("rst_rvalid", {31'd0, bus.S_AXI_RVALID}, 0);
        chk("rst_rdata", bus.S_AXI_RDATA, 0);
        chk("rst_ctrl", ctrl_out, 0);
        chk("rst_cfg", cfg_out, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        rst_n = 1;
        step();
        chk("awready_up", {31'd0, bus.S_AXI_AWREADY}, 1);
        chk("arready_up", {31'd0, bus.S_AXI_ARREADY}, 1);

        for (int a = 0; a < 8; a++) axi_read(5'(a * 4), 0, 0);

        // byte strobes on CFG
        axi_write(5'h04, 32'h0101_FFFF, 4'hF, 0, 0, 0, 0);
        axi_write(5'h04, 32'hABCD_0001, 4'h3, 0, 0, 0, 0);
        axi_read(5'h04, 0, 0);
        // W leads AW by 3 cycles with START
        axi_write(5'h00, 32'hDEAD_0011, 4'hF, 3, 0, 1, 0);
        axi_read(5'h00, 0, 0);
        // long BREADY stall, then an unmapped write
        axi_write(5'h04, 32'h1234_5678, 4'hF, 0, 0, 5, 0);
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0);
        // interrupts: set-wins on simultaneous clear
        axi_write(5'h0C, 32'hFFFF_FF05, 4'hF, 0, 0, 0, 0);
        pulse_events(8'h07);
        axi_read(5'h10, 0, 0);
        axi_write(5'h10, 32'h0000_0001, 4'hF, 0, 2, 0, 8'h01);
        axi_read(5'h10, 0, 0);
        axi_write(5'h10, 32'h0000_0005, 4'hF, 0, 0, 0, 0);
        axi_read(5'h10, 0, 0);
        // STATUS sampled at handshake, writes ignored
        status_in = 32'hBEEF_0011;
        axi_read(5'h08, 4, 1);
        axi_write(5'h08, 32'h5555_5555, 4'hF, 0, 0, 0, 0);
        status_in = 32'hBEEF_0011;
        axi_read(5'h08, 0, 0);

        for (int t = 0; t < 60; t++) begin
            int op = $urandom_range(0, 2);
            if (op == 0)
                axi_write(5'($urandom_range(0, 7) * 4), $urandom, 4'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
            else if (op == 1) begin
                status_in = $urandom;
                axi_read(5'($urandom_range(0, 7) * 4), $urandom_range(0, 3), $urandom_range(0, 1));
            end else
                pulse_events(8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
